// File: rtl/seq_detector_param.sv
// Runtime-programmable sequence detector: a step table of (input select, expected value)
// pairs replaces hard-coded FSM states; reports match pulse, done level, progress and mismatches.
module seq_detector_param #(
    parameter int N_IN      = 4,
    parameter int MAX_STEPS = 16,
    parameter int SEL_W     = $clog2(N_IN),
    parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode_cont,
    input  logic              mode_retry,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [N_IN-1:0]   in_bits,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_addr,
    input  logic [SEL_W-1:0]  cfg_sel,
    input  logic              cfg_val,
    input  logic [STEP_W-1:0] cfg_len,
    output logic              match,
    output logic              done,
    output logic [STEP_W-1:0] step,
    output logic [15:0]       mismatch_cnt
);

    localparam int IDX_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q [MAX_STEPS];
    logic              val_q [MAX_STEPS];
    logic              en_q;
    logic [STEP_W-1:0] len_q;

    logic [STEP_W-1:0] step_d;
    logic              match_d, done_d, complete;
    logic [15:0]       cnt_d;
    logic [IDX_W-1:0]  step_idx;
    logic              hit, hit0, last;

    // Out-of-range selects fall back to bit 0 so a bad table entry never indexes past in_bits.
    function automatic logic pick(input logic [N_IN-1:0] bits, input logic [SEL_W-1:0] s);
        if (int'(s) < N_IN)
            return bits[s];
        return bits[0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                sel_q[i] <= '0;
                val_q[i] <= 1'b0;
            end
            en_q  <= 1'b0;
            len_q <= '0;
        end else begin
            en_q <= en;
            if (en && !en_q)
                len_q <= (int'(cfg_len) > MAX_STEPS) ? STEP_W'(MAX_STEPS) : cfg_len;
            if (cfg_we && !en && (int'(cfg_addr) < MAX_STEPS)) begin
                sel_q[cfg_addr[IDX_W-1:0]] <= cfg_sel;
                val_q[cfg_addr[IDX_W-1:0]] <= cfg_val;
            end
        end
    end

    assign step_idx = step[IDX_W-1:0];
    assign hit      = (pick(in_bits, sel_q[step_idx]) == val_q[step_idx]);
    assign hit0     = (pick(in_bits, sel_q[0]) == val_q[0]);
    assign last     = ((step + STEP_W'(1)) == len_q);

    always_comb begin
        state_d  = state_q;
        step_d   = step;
        match_d  = 1'b0;
        done_d   = done;
        cnt_d    = mismatch_cnt;
        complete = 1'b0;
        if (!en) begin
            state_d = IDLE;
            step_d  = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    step_d  = '0;
                    done_d  = 1'b0;
                end
                RUN: begin
                    // A zero-length program never evaluates samples at all.
                    if (in_valid && (len_q != '0)) begin
                        if (hit) begin
                            if (last)
                                complete = 1'b1;
                            else
                                step_d = step + STEP_W'(1);
                        end else begin
                            cnt_d = (mismatch_cnt == 16'hFFFF) ? mismatch_cnt : mismatch_cnt + 16'd1;
                            if (mode_retry && (step != '0) && hit0) begin
                                if (len_q == STEP_W'(1))
                                    complete = 1'b1;
                                else
                                    step_d = STEP_W'(1);
                            end else begin
                                step_d = '0;
                            end
                        end
                        if (complete) begin
                            match_d = 1'b1;
                            if (mode_cont) begin
                                step_d = '0;
                            end else begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (clear) begin
                        state_d = RUN;
                        step_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            step         <= '0;
            match        <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state_q      <= state_d;
            step         <= step_d;
            match        <= match_d;
            done         <= done_d;
            mismatch_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: per-cycle vectors with expected outputs queued on drive
// and popped when the registered outputs settle after the clock edge.
module tb_seq_detector_param;

    localparam int N_IN      = 4;
    localparam int MAX_STEPS = 16;
    localparam int SEL_W     = 2;
    localparam int STEP_W    = 5;

    logic              clk;
    logic              reset;
    logic              en, mode_cont, mode_retry, clear, in_valid;
    logic [N_IN-1:0]   in_bits;
    logic              cfg_we;
    logic [STEP_W-1:0] cfg_addr;
    logic [SEL_W-1:0]  cfg_sel;
    logic              cfg_val;
    logic [STEP_W-1:0] cfg_len;
    logic              match, done;
    logic [STEP_W-1:0] step;
    logic [15:0]       mismatch_cnt;

    typedef struct packed {
        logic              en, cont, retry, clr, valid;
        logic [N_IN-1:0]   bits;
        logic              e_match, e_done;
        logic [STEP_W-1:0] e_step;
        logic [15:0]       e_cnt;
    } vec_t;

    typedef struct packed {
        logic              e_match, e_done;
        logic [STEP_W-1:0] e_step;
        logic [15:0]       e_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    vec_t tbl [10];

    seq_detector_param #(.N_IN(N_IN), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .reset(reset), .en(en), .mode_cont(mode_cont), .mode_retry(mode_retry),
        .clear(clear), .in_valid(in_valid), .in_bits(in_bits), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_val(cfg_val), .cfg_len(cfg_len),
        .match(match), .done(done), .step(step), .mismatch_cnt(mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic e, c, r, cl, v, input logic [N_IN-1:0] b,
                                input logic m, d, input int st, input int cnt);
        vec_t x;
        x.en = e; x.cont = c; x.retry = r; x.clr = cl; x.valid = v; x.bits = b;
        x.e_match = m; x.e_done = d; x.e_step = STEP_W'(st); x.e_cnt = 16'(cnt);
        return x;
    endfunction

    task automatic push_exp(input logic m, d, input logic [STEP_W-1:0] st, input logic [15:0] cnt);
        exp_t e;
        e.e_match = m; e.e_done = d; e.e_step = st; e.e_cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        if (match !== e.e_match || done !== e.e_done || step !== e.e_step || mismatch_cnt !== e.e_cnt) begin
            miscompares++;
            $display("[TB] FAIL %s: got match=%0b done=%0b step=%0d cnt=%0d, expected match=%0b done=%0b step=%0d cnt=%0d",
                     name, match, done, step, mismatch_cnt, e.e_match, e.e_done, e.e_step, e.e_cnt);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string name);
        @(negedge clk);
        en = v.en; mode_cont = v.cont; mode_retry = v.retry; clear = v.clr;
        in_valid = v.valid; in_bits = v.bits;
        push_exp(v.e_match, v.e_done, v.e_step, v.e_cnt);
        @(posedge clk);
        #1;
        check_output(name);
    endtask

    task automatic program_entry(input int addr, input int sel, input logic val, input int cnt);
        cfg_we = 1'b1; cfg_addr = STEP_W'(addr); cfg_sel = SEL_W'(sel); cfg_val = val;
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, cnt), "cfg_write");
        cfg_we = 1'b0;
    endtask

    // Correct five-sample sequence for the programmed table, starting from step 0.
    task automatic run_sequence(input logic cont, retry, input int cnt, input string name);
        apply_stimulus(mk(1, cont, retry, 0, 1, 4'b0100, 0, 0, 1, cnt), name);
        apply_stimulus(mk(1, cont, retry, 0, 1, 4'b0001, 0, 0, 2, cnt), name);
        apply_stimulus(mk(1, cont, retry, 0, 1, 4'b0000, 0, 0, 3, cnt), name);
        apply_stimulus(mk(1, cont, retry, 0, 1, 4'b1000, 0, 0, 4, cnt), name);
        apply_stimulus(mk(1, cont, retry, 0, 1, 4'b0000, 1, !cont, cont ? 0 : 4, cnt), name);
    endtask

    initial begin
        reset = 1'b0; en = 0; mode_cont = 0; mode_retry = 0; clear = 0; in_valid = 0;
        in_bits = '0; cfg_we = 0; cfg_addr = '0; cfg_sel = '0; cfg_val = 0; cfg_len = 5'd5;

        repeat (2) @(negedge clk);
        push_exp(0, 0, 0, 0);
        check_output("reset_state");
        reset = 1'b1;

        program_entry(0, 2, 1'b1, 0);
        program_entry(1, 0, 1'b1, 0);
        program_entry(2, 2, 1'b0, 0);
        program_entry(3, 3, 1'b1, 0);
        program_entry(4, 0, 1'b0, 0);

        // One-shot run, DONE hold, ignored sample in DONE, clear beating a valid sample.
        tbl[0] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 0, 0, 1, 4'b0100, 0, 0, 1, 0);
        tbl[2] = mk(1, 0, 0, 0, 1, 4'b0001, 0, 0, 2, 0);
        tbl[3] = mk(1, 0, 0, 0, 1, 4'b0000, 0, 0, 3, 0);
        tbl[4] = mk(1, 0, 0, 0, 1, 4'b1000, 0, 0, 4, 0);
        tbl[5] = mk(1, 0, 0, 0, 1, 4'b0000, 1, 1, 4, 0);
        tbl[6] = mk(1, 0, 0, 0, 0, 4'b0000, 0, 1, 4, 0);
        tbl[7] = mk(1, 0, 0, 0, 1, 4'b1111, 0, 1, 4, 0);
        tbl[8] = mk(1, 0, 0, 1, 1, 4'b0100, 0, 0, 0, 0);
        tbl[9] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            apply_stimulus(tbl[i], $sformatf("oneshot_v%0d", i));

        // Retry: miss at step 2 that hits step 0 lands on step 1.
        apply_stimulus(mk(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0), "retry_rise");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b0100, 0, 0, 1, 0), "retry_s0");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b0001, 0, 0, 2, 0), "retry_s1");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b0100, 0, 0, 1, 1), "retry_miss");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b0001, 0, 0, 2, 1), "retry_c1");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b0000, 0, 0, 3, 1), "retry_c2");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b1000, 0, 0, 4, 1), "retry_c3");
        apply_stimulus(mk(1, 0, 1, 0, 1, 4'b0000, 1, 1, 4, 1), "retry_match");
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1), "retry_idle");

        // No retry: same miss returns to step 0, then a full replay matches.
        apply_stimulus(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1), "noretry_rise");
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0100, 0, 0, 1, 1), "noretry_s0");
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0001, 0, 0, 2, 1), "noretry_s1");
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0100, 0, 0, 0, 2), "noretry_miss");
        run_sequence(0, 0, 2, "noretry_replay");
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "noretry_idle");

        // Continuous: two back-to-back matches, done never rises.
        apply_stimulus(mk(1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "cont_rise");
        run_sequence(1, 0, 2, "cont_first");
        run_sequence(1, 0, 2, "cont_second");
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "cont_idle");

        // Out-of-range address and writes while enabled must leave step 0 as (sel=2,val=1).
        cfg_we = 1'b1; cfg_addr = 5'd16; cfg_sel = 2'd1; cfg_val = 1'b0;
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "cfg_oob");
        cfg_we = 1'b0;
        apply_stimulus(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "cfg_rise");
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_sel = 2'd1; cfg_val = 1'b0;
        apply_stimulus(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "cfg_we_en");
        cfg_we = 1'b0;
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0110, 0, 0, 1, 2), "cfg_unchanged");
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "cfg_idle");

        // Async reset at step 3, then a zero-length program that never matches.
        apply_stimulus(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 2), "rst_rise");
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0100, 0, 0, 1, 2), "rst_s0");
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0001, 0, 0, 2, 2), "rst_s1");
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0000, 0, 0, 3, 2), "rst_s2");
        #2;
        reset = 1'b0;
        #1;
        push_exp(0, 0, 0, 0);
        check_output("async_reset");
        @(negedge clk);
        cfg_len = 5'd0;
        reset   = 1'b1;
        for (int i = 0; i < 6; i++)
            apply_stimulus(mk(1, 0, 0, 0, i > 0, 4'b0000, 0, 0, 0, 0), $sformatf("len0_v%0d", i));

        // Length above MAX_STEPS clamps to 16; the cleared table (sel=0,val=0) hits on 0000.
        apply_stimulus(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), "clamp_idle");
        cfg_len = 5'd31;
        apply_stimulus(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0), "clamp_rise");
        for (int i = 1; i <= 15; i++)
            apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0000, 0, 0, i, 0), $sformatf("clamp_s%0d", i));
        apply_stimulus(mk(1, 0, 0, 0, 1, 4'b0000, 1, 1, 15, 0), "clamp_match");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
